// File: rtl/cache_arbiter.sv
// cache_arbiter
// Arbitrates the LC-3b fetch port (read-only) and memory-stage port
// (read/write) onto a single 128-bit physical memory port, one line
// transaction at a time, and answers each client with a one-cycle resp pulse.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   if_read/if_addr              fetch line read request (held until if_resp)
//   if_rdata/if_resp             fetch line data + one-cycle completion pulse
//   d_read/d_write/d_addr/d_wdata memory-stage request (held until d_resp)
//   d_rdata/d_resp               memory-stage read data + completion pulse
//   pmem_read/pmem_write         physical strobes, held until pmem_resp
//   pmem_addr/pmem_wdata         latched line address / write data
//   pmem_rdata/pmem_resp         physical read data + one-cycle completion
module cache_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         if_read,
    input  logic [15:0]  if_addr,
    output logic [127:0] if_rdata,
    output logic         if_resp,
    input  logic         d_read,
    input  logic         d_write,
    input  logic [15:0]  d_addr,
    input  logic [127:0] d_wdata,
    output logic [127:0] d_rdata,
    output logic         d_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [15:0]  pmem_addr,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [2:0] {IDLE, SERVE_I, SERVE_D, DONE_I, DONE_D} state_e;

    state_e         state_q;
    logic [3:0]     starve_q, starve_d;
    logic           pmem_read_q, pmem_write_q;
    logic [15:0]    pmem_addr_q;
    logic [127:0]   pmem_wdata_q;
    logic [127:0]   if_rdata_q, d_rdata_q;
    logic           if_resp_q, d_resp_q;
    logic           d_req, grant_i, grant_d;

    // Line offset bits never reach pmem.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[3:0], d_addr[3:0]};

    // Grant decision is only meaningful in IDLE. D wins ties unless the
    // fetch port has already watched LIMIT D grants go by.
    always_comb begin
        d_req    = d_read | d_write;
        grant_i  = (state_q == IDLE) && if_read && (!d_req || starve_q == LIMIT);
        grant_d  = (state_q == IDLE) && d_req && !grant_i;
        starve_d = starve_q;
        if (grant_i)
            starve_d = 4'd0;
        else if (grant_d)
            starve_d = !if_read ? 4'd0 : (starve_q == LIMIT ? starve_q : starve_q + 4'd1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            starve_q     <= 4'd0;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            pmem_addr_q  <= 16'd0;
            pmem_wdata_q <= 128'd0;
            if_rdata_q   <= 128'd0;
            d_rdata_q    <= 128'd0;
            if_resp_q    <= 1'b0;
            d_resp_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    starve_q <= starve_d;
                    if (grant_i) begin
                        pmem_read_q <= 1'b1;
                        pmem_addr_q <= {if_addr[15:4], 4'b0};
                        state_q     <= SERVE_I;
                    end else if (grant_d) begin
                        // read+write together is treated as a write
                        pmem_read_q  <= !d_write;
                        pmem_write_q <= d_write;
                        pmem_addr_q  <= {d_addr[15:4], 4'b0};
                        pmem_wdata_q <= d_wdata;
                        state_q      <= SERVE_D;
                    end
                end
                SERVE_I: begin
                    if (pmem_resp) begin
                        pmem_read_q <= 1'b0;
                        if_rdata_q  <= pmem_rdata;
                        if_resp_q   <= 1'b1;
                        state_q     <= DONE_I;
                    end
                end
                SERVE_D: begin
                    if (pmem_resp) begin
                        if (pmem_read_q) d_rdata_q <= pmem_rdata;
                        pmem_read_q  <= 1'b0;
                        pmem_write_q <= 1'b0;
                        d_resp_q     <= 1'b1;
                        state_q      <= DONE_D;
                    end
                end
                DONE_I: begin
                    if_resp_q <= 1'b0;
                    state_q   <= IDLE;
                end
                DONE_D: begin
                    d_resp_q <= 1'b0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign pmem_read  = pmem_read_q;
    assign pmem_write = pmem_write_q;
    assign pmem_addr  = pmem_addr_q;
    assign pmem_wdata = pmem_wdata_q;
    assign if_rdata   = if_rdata_q;
    assign if_resp    = if_resp_q;
    assign d_rdata    = d_rdata_q;
    assign d_resp     = d_resp_q;

endmodule
